// File: rtl/unit_arbiter.sv
// unit_arbiter: round-robin front end that shares one multi-cycle functional
// unit between NREQ requesters. One transaction is in flight at a time; a
// watchdog turns a hung unit into an error response.
module unit_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_error,
  output logic                  unit_input_valid,
  input  logic                  unit_ready,
  output logic [WIDTH-1:0]      unit_data,
  input  logic                  unit_valid,
  input  logic [WIDTH-1:0]      unit_result,
  output logic                  unit_output_ready
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNTW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam bit          TO_EN = (TIMEOUT != 0);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [IDXW-1:0] PTR_RST  = IDXW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESPOND
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [WIDTH-1:0]  operand_q, operand_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              err_q, err_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]  req_word [NREQ];
  logic              grant_found;
  logic [IDXW-1:0]   grant_idx;
  int unsigned       cand;

  // Unpack the flat operand bus into one word per requester.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_word[g] = req_data[g*WIDTH +: WIDTH];
  end

  // Round-robin pick: first valid requester scanning from ptr+1 upward.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(ptr_q) + k) % NREQ;
      if (!grant_found && req_valid[IDXW'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDXW'(cand);
      end
    end
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= PTR_RST;
      owner_q   <= '0;
      operand_q <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      operand_q <= operand_d;
      result_q  <= result_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic: accept, issue, wait (with watchdog), respond.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    operand_d = operand_q;
    result_d  = result_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          operand_d = req_word[grant_idx];
          owner_d   = grant_idx;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (unit_ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A result arriving in the expiry cycle takes priority over the error.
        if (unit_valid) begin
          result_d = unit_result;
          err_d    = 1'b0;
          state_d  = ST_RESPOND;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = ST_RESPOND;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      ST_RESPOND: begin
        if (rsp_ready[owner_q]) begin
          ptr_d   = owner_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request accept strobe: the only output that looks at live inputs.
  always_comb begin
    req_ready = '0;
    if ((state_q == ST_IDLE) && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Response strobe, one-hot to the transaction owner.
  always_comb begin
    rsp_valid = '0;
    if (state_q == ST_RESPOND) begin
      rsp_valid[owner_q] = 1'b1;
    end
  end

  assign rsp_data          = (state_q == ST_RESPOND) ? result_q : '0;
  assign rsp_error         = (state_q == ST_RESPOND) && err_q;
  assign unit_input_valid  = (state_q == ST_ISSUE);
  assign unit_data         = (state_q == ST_ISSUE) ? operand_q : '0;
  assign unit_output_ready = (state_q == ST_WAIT);

endmodule

// File: tb/tb_unit_arbiter.sv
// tb_unit_arbiter: directed scoreboard bench for unit_arbiter (NREQ=2,
// TIMEOUT=8). The main process issues requests and queues the expected grants
// and responses; a monitor pops and compares whenever the DUT hands them out.
module tb_unit_arbiter;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMEOUT = 8;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_data;
  logic [31:0] rsp_data, unit_data, unit_result;
  logic        rsp_error, unit_input_valid, unit_ready, unit_valid, unit_output_ready;

  typedef struct {
    int          owner;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  int   exp_grant[$];
  rsp_t exp_rsp[$];
  int   acc_cyc[$];
  int   rsp_cyc[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  int   wait_cnt = 0;

  // Behavioral unit controls.
  int          lat;
  bit          hang;
  bit          inject;
  logic        busy;
  int          ucnt;
  logic [31:0] hold;

  unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_error(rsp_error),
    .unit_input_valid(unit_input_valid), .unit_ready(unit_ready), .unit_data(unit_data),
    .unit_valid(unit_valid), .unit_result(unit_result),
    .unit_output_ready(unit_output_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic note_fail(input string nm);
    n_vec++;
    n_miss++;
    $display("FAIL %s", nm);
  endtask

  // Unit model: echoes operand+1 after lat extra cycles, or never when hung.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      unit_valid  <= 1'b0;
      unit_result <= '0;
      busy        <= 1'b0;
      ucnt        <= 0;
      hold        <= '0;
    end else begin
      unit_valid <= 1'b0;
      if (inject) begin
        unit_valid  <= 1'b1;
        unit_result <= 32'hDEAD_BEEF;
      end
      if (busy) begin
        if (ucnt == 0) begin
          unit_valid  <= 1'b1;
          unit_result <= hold;
          busy        <= 1'b0;
        end else begin
          ucnt <= ucnt - 1;
        end
      end else if (unit_input_valid && unit_ready && !hang) begin
        if (lat == 0) begin
          unit_valid  <= 1'b1;
          unit_result <= unit_data + 32'd1;
        end else begin
          busy <= 1'b1;
          ucnt <= lat - 1;
          hold <= unit_data + 32'd1;
        end
      end
    end
  end

  // Monitor: compare grants and completed responses against the scoreboard.
  initial begin : mon
    int          gi;
    rsp_t        e;
    logic [1:0]  oh;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (req_ready != 2'b00) begin
          gi = req_ready[1] ? 1 : 0;
          chk("req_ready_onehot", 64'($onehot(req_ready)), 64'(1));
          chk("grant_has_valid", 64'(req_valid[gi]), 64'(1));
          if (exp_grant.size() == 0) note_fail("unexpected_grant");
          else chk("grant_idx", 64'(gi), 64'(exp_grant.pop_front()));
          acc_cyc.push_back(cyc);
        end
        if ((rsp_valid & rsp_ready) != 2'b00) begin
          if (exp_rsp.size() == 0) begin
            note_fail("unexpected_rsp");
          end else begin
            e  = exp_rsp.pop_front();
            oh = 2'(1 << e.owner);
            chk("rsp_owner", 64'(rsp_valid), 64'(oh));
            chk("rsp_data", 64'(rsp_data), 64'(e.data));
            chk("rsp_error", 64'(rsp_error), 64'(e.err));
          end
          rsp_cyc.push_back(cyc);
        end
        if (unit_output_ready) wait_cnt++;
      end
    end
  end

  task automatic push_rsp(input int owner, input logic [31:0] data, input logic err);
    rsp_t r;
    r.owner = owner;
    r.data  = data;
    r.err   = err;
    exp_rsp.push_back(r);
  endtask

  // Wait (bounded) until every queued grant was seen; returns 1ns after a posedge.
  task automatic wait_grants(input int maxc, input string nm);
    int k = 0;
    while (exp_grant.size() != 0 && k < maxc) begin
      @(posedge clk);
      k++;
    end
    chk({"grants_done_", nm}, 64'(exp_grant.size()), 64'(0));
    #1;
  endtask

  // Wait (bounded) until every queued response completed.
  task automatic drain(input int maxc, input string nm);
    int k = 0;
    while ((exp_grant.size() != 0 || exp_rsp.size() != 0) && k < maxc) begin
      @(posedge clk);
      k++;
    end
    chk({"drained_", nm}, 64'(exp_rsp.size()), 64'(0));
    #1;
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_req_ready"}, 64'(req_ready), 64'(0));
    chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({nm, "_rsp_data"}, 64'(rsp_data), 64'(0));
    chk({nm, "_rsp_error"}, 64'(rsp_error), 64'(0));
    chk({nm, "_unit_in_valid"}, 64'(unit_input_valid), 64'(0));
    chk({nm, "_unit_data"}, 64'(unit_data), 64'(0));
    chk({nm, "_unit_out_ready"}, 64'(unit_output_ready), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL sim_time_limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b0; req_valid = '0; req_data = '0; rsp_ready = '0; unit_ready = 1'b0;
    lat = 0; hang = 1'b0; inject = 1'b0;
    #1 reset = 1'b1;
    #2 chk_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Back-to-back contention: grants alternate 0,1,0,1 every 4 cycles.
    unit_ready = 1'b1; rsp_ready = 2'b11; lat = 0;
    req_data = {32'h22, 32'h11};
    exp_grant = '{0, 1, 0, 1};
    push_rsp(0, 32'h12, 1'b0); push_rsp(1, 32'h23, 1'b0);
    push_rsp(0, 32'h12, 1'b0); push_rsp(1, 32'h23, 1'b0);
    acc_cyc.delete(); rsp_cyc.delete();
    req_valid = 2'b11;
    wait_grants(40, "t1");
    req_valid = 2'b00;
    drain(40, "t1");
    chk("t1_nrsp", 64'(rsp_cyc.size()), 64'(4));
    if (rsp_cyc.size() > 0 && acc_cyc.size() > 0)
      chk("t1_latency", 64'(rsp_cyc[0] - acc_cyc[0]), 64'(3));
    for (int i = 1; i < rsp_cyc.size(); i++)
      chk("t1_spacing", 64'(rsp_cyc[i] - rsp_cyc[i-1]), 64'(4));

    // Single requester 1, unit latency 2: every grant goes to 1.
    lat = 2;
    req_data = {32'h55, 32'h0};
    exp_grant = '{1, 1, 1};
    push_rsp(1, 32'h56, 1'b0); push_rsp(1, 32'h56, 1'b0); push_rsp(1, 32'h56, 1'b0);
    rsp_cyc.delete();
    req_valid = 2'b10;
    wait_grants(60, "t2");
    req_valid = 2'b00;
    drain(60, "t2");
    chk("t2_nrsp", 64'(rsp_cyc.size()), 64'(3));
    for (int i = 1; i < rsp_cyc.size(); i++)
      chk("t2_spacing", 64'(rsp_cyc[i] - rsp_cyc[i-1]), 64'(6));

    // Stalls: unit_ready low in ISSUE, then rsp_ready low in RESPOND.
    lat = 1; unit_ready = 1'b0; rsp_ready = 2'b00;
    req_data = {32'h0, 32'hA5A5_0001};
    exp_grant = '{0};
    push_rsp(0, 32'hA5A5_0002, 1'b0);
    req_valid = 2'b01;
    k = 0;
    do begin @(negedge clk); k++; end while (!unit_input_valid && k < 10);
    chk("t3_issue_seen", 64'(unit_input_valid), 64'(1));
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("t3_issue_valid", 64'(unit_input_valid), 64'(1));
      chk("t3_issue_data", 64'(unit_data), 64'(32'hA5A5_0001));
      chk("t3_issue_req_ready", 64'(req_ready), 64'(0));
    end
    @(posedge clk); #1 unit_ready = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (rsp_valid == 2'b00 && k < 10);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("t3_hold_rsp_valid", 64'(rsp_valid), 64'(2'b01));
      chk("t3_hold_rsp_data", 64'(rsp_data), 64'(32'hA5A5_0002));
      chk("t3_hold_rsp_error", 64'(rsp_error), 64'(0));
      chk("t3_hold_req_ready", 64'(req_ready), 64'(0));
    end
    @(posedge clk); #1 rsp_ready = 2'b11; req_valid = 2'b00;
    drain(20, "t3");

    // Timeout: unit hangs, WAIT lasts exactly 8 cycles, error response.
    hang = 1'b1;
    req_data = {32'h0, 32'h77};
    exp_grant = '{0};
    push_rsp(0, 32'h0, 1'b1);
    acc_cyc.delete(); rsp_cyc.delete(); wait_cnt = 0;
    req_valid = 2'b01;
    wait_grants(20, "t4");
    req_valid = 2'b00;
    drain(40, "t4");
    chk("t4_wait_cycles", 64'(wait_cnt), 64'(8));
    if (rsp_cyc.size() > 0 && acc_cyc.size() > 0)
      chk("t4_latency", 64'(rsp_cyc[0] - acc_cyc[0]), 64'(10));
    // A late result pulse must not create a response.
    inject = 1'b1;
    @(posedge clk); #1 inject = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_late_rsp_valid", 64'(rsp_valid), 64'(0));
    end
    @(posedge clk); #1;
    // Next transaction completes normally.
    hang = 1'b0; lat = 0;
    req_data = {32'h0, 32'h100};
    exp_grant = '{0};
    push_rsp(0, 32'h101, 1'b0);
    acc_cyc.delete(); rsp_cyc.delete();
    req_valid = 2'b01;
    wait_grants(20, "t4b");
    req_valid = 2'b00;
    drain(20, "t4b");
    if (rsp_cyc.size() > 0 && acc_cyc.size() > 0)
      chk("t4b_latency", 64'(rsp_cyc[0] - acc_cyc[0]), 64'(3));

    // Timeout tie: result arrives in the 8th WAIT cycle and wins.
    lat = 7;
    req_data = {32'h0, 32'h200};
    exp_grant = '{0};
    push_rsp(0, 32'h201, 1'b0);
    acc_cyc.delete(); rsp_cyc.delete(); wait_cnt = 0;
    req_valid = 2'b01;
    wait_grants(20, "t5");
    req_valid = 2'b00;
    drain(40, "t5");
    chk("t5_wait_cycles", 64'(wait_cnt), 64'(8));
    if (rsp_cyc.size() > 0 && acc_cyc.size() > 0)
      chk("t5_latency", 64'(rsp_cyc[0] - acc_cyc[0]), 64'(10));

    // Async reset mid-WAIT: outputs clear at once, requester 0 wins afterwards.
    hang = 1'b1;
    req_data = {32'h0, 32'h300};
    exp_grant = '{0};
    req_valid = 2'b01;
    wait_grants(20, "t6");
    req_valid = 2'b00;
    k = 0;
    do begin @(negedge clk); k++; end while (!unit_output_ready && k < 10);
    chk("t6_in_wait", 64'(unit_output_ready), 64'(1));
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_outputs_zero("t6_async");
    @(posedge clk); #1 reset = 1'b0;
    hang = 1'b0; lat = 0;
    req_data = {32'h500, 32'h400};
    exp_grant = '{0, 1};
    push_rsp(0, 32'h401, 1'b0); push_rsp(1, 32'h501, 1'b0);
    req_valid = 2'b11;
    wait_grants(20, "t6b");
    req_valid = 2'b00;
    drain(20, "t6b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
